// File: rtl/pulse_meter_pkg.sv
// Shared definitions for the pulse propagation measurement block:
// sequencer state encoding, default parameter values and the timeout code.
package pulse_meter_pkg;

   // Sequencer states, 3-bit encoding.
   typedef enum logic [2:0] {
      IDLE = 3'd0,
      ARM  = 3'd1,
      FIRE = 3'd2,
      WAIT = 3'd3,
      DONE = 3'd4
   } state_e;

   localparam int DEF_CNT_W   = 16;
   localparam int DEF_PULSE_W = 4;
   localparam int DEF_QUIET   = 8;
   localparam int DEF_TIMEOUT = 50000;

   // Count value reported when no echo arrives (all ones at the default width).
   localparam logic [DEF_CNT_W-1:0] TIMEOUT_CODE = '1;

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer followed by a history flop for rising-edge detection.
// level_o is the synchronized level; rise_o is a one-cycle strobe on its 0->1 edge.
module sync_edge_det #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk_i,
   input  logic rst_n_i,
   input  logic d_i,
   output logic level_o,
   output logic rise_o
);

   logic meta_q;
   logic sync_q;
   logic hist_q;

   // Synchronizer chain plus one extra stage of history for the edge detector.
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         meta_q <= RST_VAL;
         sync_q <= RST_VAL;
         hist_q <= RST_VAL;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
         hist_q <= sync_q;
      end
   end

   assign level_o = sync_q;
   assign rise_o  = sync_q & ~hist_q;

endmodule

// File: rtl/pulse_measure_ctrl.sv
// Pulse propagation measurement sequencer.
// A rising edge on i_Start (in IDLE only) arms the block; once the echo line has
// been quiet for QUIET cycles a PULSE_W-cycle test pulse fires and a counter runs
// from 0 until the synchronized echo rising edge or TIMEOUT-1.
// Output qualification: o_Done is a single-cycle strobe marking the end of a
// measurement; o_Valid / o_Timeout / o_Count are registered, already correct in
// the o_Done cycle, and hold until the next accepted start. There is no
// back-pressure: the consumer must sample on o_Done.
// The FSM state is held in state_q for observation.
module pulse_measure_ctrl
   import pulse_meter_pkg::*;
#(
   parameter int CNT_W   = DEF_CNT_W,
   parameter int PULSE_W = DEF_PULSE_W,
   parameter int QUIET   = DEF_QUIET,
   parameter int TIMEOUT = DEF_TIMEOUT
) (
   input  logic             i_Clk,
   input  logic             i_Rst_n,
   input  logic             i_Start,
   input  logic             i_Echo,
   output logic             o_Pulse,
   output logic             o_Busy,
   output logic             o_Done,
   output logic             o_Valid,
   output logic             o_Timeout,
   output logic [CNT_W-1:0] o_Count
);

   localparam int QW = $clog2(QUIET + 1);

   localparam logic [QW-1:0]    QUIET_LAST  = QW'(QUIET - 1);
   localparam logic [CNT_W-1:0] PULSE_LAST  = CNT_W'(PULSE_W - 1);
   localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_TIMEOUT = {CNT_W{1'b1}};

   state_e           state_q,   state_d;
   logic [CNT_W-1:0] cnt_q,     cnt_d;
   logic [QW-1:0]    quiet_q,   quiet_d;
   logic             pulse_q,   pulse_d;
   logic             valid_q,   valid_d;
   logic             timeout_q, timeout_d;
   logic [CNT_W-1:0] count_q,   count_d;
   logic             start_q;

   logic echo_s;
   logic echo_rise;
   logic start_evt;

   sync_edge_det #(
      .RST_VAL (1'b0)
   ) u_echo_sync (
      .clk_i   (i_Clk),
      .rst_n_i (i_Rst_n),
      .d_i     (i_Echo),
      .level_o (echo_s),
      .rise_o  (echo_rise)
   );

   // The start history resets high so a level held through reset is not an edge.
   assign start_evt = i_Start & ~start_q;

   // State, counters and result registers.
   always_ff @(posedge i_Clk) begin
      if (!i_Rst_n) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         quiet_q   <= '0;
         pulse_q   <= 1'b0;
         valid_q   <= 1'b0;
         timeout_q <= 1'b0;
         count_q   <= '0;
         start_q   <= 1'b1;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         quiet_q   <= quiet_d;
         pulse_q   <= pulse_d;
         valid_q   <= valid_d;
         timeout_q <= timeout_d;
         count_q   <= count_d;
         start_q   <= i_Start;
      end
   end

   // Next-state and result logic; cnt_q is the wait counter in ARM and the
   // propagation counter in FIRE/WAIT.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      quiet_d   = quiet_q;
      valid_d   = valid_q;
      timeout_d = timeout_q;
      count_d   = count_q;
      case (state_q)
         IDLE: begin
            if (start_evt) begin
               state_d   = ARM;
               valid_d   = 1'b0;
               timeout_d = 1'b0;
               cnt_d     = '0;
               quiet_d   = '0;
            end
         end
         ARM: begin
            cnt_d   = cnt_q + CNT_W'(1);
            quiet_d = echo_s ? '0 : quiet_q + QW'(1);
            if (!echo_s && (quiet_q == QUIET_LAST)) begin
               state_d = FIRE;
               cnt_d   = '0;
               quiet_d = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d   = DONE;
               count_d   = CNT_TIMEOUT;
               timeout_d = 1'b1;
            end
         end
         FIRE: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (echo_rise) begin
               state_d = DONE;
               count_d = cnt_q;
               valid_d = 1'b1;
            end else if (cnt_q == PULSE_LAST) begin
               state_d = WAIT;
            end
         end
         WAIT: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (echo_rise) begin
               state_d = DONE;
               count_d = cnt_q;
               valid_d = 1'b1;
            end else if (cnt_q == CNT_LAST) begin
               state_d   = DONE;
               count_d   = CNT_TIMEOUT;
               timeout_d = 1'b1;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      // Pulse is high exactly while the next state is FIRE, so it rises on the
      // FIRE entry edge and drops on the edge that leaves FIRE.
      pulse_d = (state_d == FIRE);
   end

   assign o_Pulse   = pulse_q;
   assign o_Busy    = (state_q != IDLE);
   assign o_Done    = (state_q == DONE);
   assign o_Valid   = valid_q;
   assign o_Timeout = timeout_q;
   assign o_Count   = count_q;

endmodule

// File: tb/tb_pulse_measure_ctrl.sv
// Directed bench for pulse_measure_ctrl with a behavioural echo line
// (none, stuck high, or o_Pulse delayed by a whole number of cycles).
module tb_pulse_measure_ctrl;

   localparam int CNT_W   = 16;
   localparam int PULSE_W = 4;
   localparam int QUIET   = 8;
   localparam int TIMEOUT = 100;
   localparam int W       = CNT_W + 2;

   localparam logic [CNT_W-1:0] ONES = {CNT_W{1'b1}};

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #10 clk = ~clk;

   logic             i_Rst_n = 1'b0;
   logic             i_Start = 1'b0;
   logic             i_Echo;
   logic             o_Pulse;
   logic             o_Busy;
   logic             o_Done;
   logic             o_Valid;
   logic             o_Timeout;
   logic [CNT_W-1:0] o_Count;

   pulse_measure_ctrl #(
      .CNT_W   (CNT_W),
      .PULSE_W (PULSE_W),
      .QUIET   (QUIET),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .i_Clk     (clk),
      .i_Rst_n   (i_Rst_n),
      .i_Start   (i_Start),
      .i_Echo    (i_Echo),
      .o_Pulse   (o_Pulse),
      .o_Busy    (o_Busy),
      .o_Done    (o_Done),
      .o_Valid   (o_Valid),
      .o_Timeout (o_Timeout),
      .o_Count   (o_Count)
   );

   // ---------------- echo line model ----------------
   int           echo_mode = 0;   // 0 none, 1 stuck high, 2 delayed pulse
   int           echo_dly  = 0;
   logic [127:0] dly_q     = '0;

   always @(posedge clk) dly_q <= {dly_q[126:0], o_Pulse};

   always_comb begin
      i_Echo = 1'b0;
      case (echo_mode)
         1: i_Echo = 1'b1;
         2: i_Echo = (echo_dly == 0) ? o_Pulse : dly_q[7'(echo_dly - 1)];
         default: i_Echo = 1'b0;
      endcase
   end

   // ---------------- scoreboard ----------------
   logic [W-1:0] exp_q[$];
   int n_checks = 0;
   int n_pass   = 0;
   int n_done   = 0;
   int exp_done = 0;
   int pw_cnt   = 0;
   int busy_cnt = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Monitor: pops an expected result on every o_Done, checks strobe width,
   // and tallies pulse-high and busy cycles for the driver.
   initial begin
      logic [W-1:0] e;
      logic         done_prev;
      done_prev = 1'b0;
      forever begin
         @(negedge clk);
         if (o_Pulse === 1'b1) pw_cnt++;
         if (o_Busy === 1'b1) busy_cnt++;
         if (o_Done === 1'b1) begin
            n_done++;
            check("done_width", 32'(done_prev), 32'd0);
            if (exp_q.size() == 0) begin
               n_checks++;
               $display("FAIL unexpected_done: o_Done with nothing expected, count=%0h", o_Count);
            end else begin
               e = exp_q.pop_front();
               check("result", 32'({o_Valid, o_Timeout, o_Count}), 32'(e));
            end
         end
         done_prev = o_Done;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic run_meas(input string name, input int mode, input int dly, input bit retrig,
                           input logic [W-1:0] exp, input int exp_lat, input int exp_pw);
      int lat;
      bit got;
      echo_mode = mode;
      echo_dly  = dly;
      repeat (3) @(negedge clk);
      pw_cnt = 0;
      i_Start = 1'b1;
      exp_q.push_back(exp);
      exp_done++;
      lat = 0;
      got = 1'b0;
      while (!got && lat < 400) begin
         @(negedge clk);
         lat++;
         if (retrig && lat == 3) i_Start = 1'b0;
         if (retrig && lat == 4) i_Start = 1'b1;
         if (o_Done === 1'b1) got = 1'b1;
      end
      if (!got) begin
         n_checks++;
         $display("FAIL %s_no_done: no o_Done within 400 cycles", name);
      end else begin
         check({name, "_latency"}, 32'(lat), 32'(exp_lat));
         check({name, "_pulse_width"}, 32'(pw_cnt), 32'(exp_pw));
      end
      i_Start = 1'b0;
      repeat (140) @(negedge clk);
      check({name, "_done_count"}, 32'(n_done), 32'(exp_done));
   endtask

   task automatic reset_mid(input string name, input bit in_wait);
      int n;
      echo_mode = 0;
      repeat (3) @(negedge clk);
      i_Start = 1'b1;
      n = 0;
      while (o_Pulse !== 1'b1 && n < 40) begin @(negedge clk); n++; end
      if (in_wait) begin
         while (o_Pulse !== 1'b0 && n < 80) begin @(negedge clk); n++; end
         repeat (5) @(negedge clk);
      end
      check({name, "_busy_before"}, 32'(o_Busy), 32'd1);
      i_Rst_n = 1'b0;
      @(negedge clk);
      check({name, "_pulse"},   32'(o_Pulse),   32'd0);
      check({name, "_busy"},    32'(o_Busy),    32'd0);
      check({name, "_done"},    32'(o_Done),    32'd0);
      check({name, "_valid"},   32'(o_Valid),   32'd0);
      check({name, "_timeout"}, 32'(o_Timeout), 32'd0);
      check({name, "_count"},   32'(o_Count),   32'd0);
      repeat (2) @(negedge clk);
      i_Rst_n = 1'b1;
      busy_cnt = 0;
      repeat (30) @(negedge clk);
      check({name, "_start_held_idle"}, 32'(busy_cnt), 32'd0);
      check({name, "_done_count"}, 32'(n_done), 32'(exp_done));
      i_Start = 1'b0;
      repeat (5) @(negedge clk);
   endtask

   // ---------------- test sequence ----------------
   initial begin
      i_Rst_n = 1'b0;
      i_Start = 1'b0;
      repeat (5) @(negedge clk);
      check("reset_pulse",   32'(o_Pulse),   32'd0);
      check("reset_busy",    32'(o_Busy),    32'd0);
      check("reset_done",    32'(o_Done),    32'd0);
      check("reset_valid",   32'(o_Valid),   32'd0);
      check("reset_timeout", 32'(o_Timeout), 32'd0);
      check("reset_count",   32'(o_Count),   32'd0);
      i_Rst_n = 1'b1;
      repeat (5) @(negedge clk);

      // name, echo mode, delay, retrigger, {valid,timeout,count}, done latency, pulse cycles
      run_meas("loopback",   2, 0,  1'b0, {2'b10, 16'd2},  QUIET + 2 + 2,       3);
      run_meas("delay10",    2, 10, 1'b0, {2'b10, 16'd12}, QUIET + 2 + 12,      PULSE_W);
      run_meas("no_echo",    0, 0,  1'b0, {2'b01, ONES},   QUIET + 1 + TIMEOUT, PULSE_W);
      run_meas("echo_stuck", 1, 0,  1'b0, {2'b01, ONES},   TIMEOUT + 1,         0);
      run_meas("edge_wins",  2, 97, 1'b0, {2'b10, 16'd99}, QUIET + 2 + 99,      PULSE_W);
      run_meas("edge_late",  2, 98, 1'b0, {2'b01, ONES},   QUIET + 1 + TIMEOUT, PULSE_W);
      run_meas("retrigger",  2, 10, 1'b1, {2'b10, 16'd12}, QUIET + 2 + 12,      PULSE_W);
      reset_mid("rst_wait", 1'b1);
      reset_mid("rst_fire", 1'b0);
      run_meas("recover",    2, 5,  1'b0, {2'b10, 16'd7},  QUIET + 2 + 7,       PULSE_W);

      check("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   // Global time bound so the run always ends.
   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("%0d/%0d checks passed", n_pass, n_checks + 1);
      $fatal(1, "watchdog");
   end

endmodule
